mult_fu_pipe: RTL

- Parametrised pipelined integer multiply functional unit for the execute stage. Successor to the fixed 2-cycle multiplier slot.
- Accepts one RV32M multiply per cycle under a valid/ready handshake.
- Carries ROB/PRN metadata alongside the operands through a configurable number of stages.
- Supports output backpressure and pipeline flush. Results go to the writeback/CDB arbiter.

---
 rtl/mult_fu_if.sv | 30 +++
 rtl/mult_fu_pipe.sv | 112 +++++++++++
 2 files changed

// File: rtl/mult_fu_if.sv
// Issue/result channel between the execute-stage scheduler and the multiply unit.
// The scheduler drives the master side and the functional unit uses the slave side.
interface mult_fu_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned ROB_W = 6,
  parameter int unsigned PRN_W = 6
);
  logic             in_valid;
  logic             in_ready;
  logic [XLEN-1:0]  in_opa;
  logic [XLEN-1:0]  in_opb;
  logic [1:0]       in_func;
  logic [ROB_W-1:0] in_rob_entry;
  logic [PRN_W-1:0] in_dest_prn;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_result;
  logic [ROB_W-1:0] out_rob_entry;
  logic [PRN_W-1:0] out_dest_prn;

  modport master (
    output in_valid, in_opa, in_opb, in_func, in_rob_entry, in_dest_prn, out_ready,
    input  in_ready, out_valid, out_result, out_rob_entry, out_dest_prn
  );

  modport slave (
    input  in_valid, in_opa, in_opb, in_func, in_rob_entry, in_dest_prn, out_ready,
    output in_ready, out_valid, out_result, out_rob_entry, out_dest_prn
  );
endinterface

// File: rtl/mult_fu_pipe.sv
// Pipelined RV32M multiply unit: STAGES-deep result/tag pipe, global stall, flush.
// Define MULT_FU_STALL_CNT_EN to add a saturating stall_cnt output.
module mult_fu_pipe #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned STAGES = 2,
  parameter int unsigned ROB_W  = 6,
  parameter int unsigned PRN_W  = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pipe_flush,
  mult_fu_if.slave    io
`ifdef MULT_FU_STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  localparam int unsigned PW = 2 * XLEN + 2;
  localparam int unsigned IW = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam logic [IW-1:0] LAST = IW'(STAGES - 1);

  typedef struct packed {
    logic [XLEN-1:0]  result;
    logic [ROB_W-1:0] rob;
    logic [PRN_W-1:0] prn;
  } stage_t;

  logic              stall;
  logic              sign_a;
  logic              sign_b;
  logic [XLEN:0]     opa_ext;
  logic [XLEN:0]     opb_ext;
  logic signed [PW-1:0] prod;
  logic [XLEN-1:0]   res_sel;
  logic              unused_prod_hi;

  logic [STAGES-1:0] valid_q, valid_d;
  stage_t            stage_q [STAGES];
  stage_t            stage_d [STAGES];

  // Full product is formed ahead of stage 0; later stages only carry it with its tags.
  always_comb begin
    sign_a  = (io.in_func == 2'd1) || (io.in_func == 2'd2);
    sign_b  = (io.in_func == 2'd1);
    opa_ext = {sign_a & io.in_opa[XLEN-1], io.in_opa};
    opb_ext = {sign_b & io.in_opb[XLEN-1], io.in_opb};
    prod    = PW'($signed(opa_ext)) * PW'($signed(opb_ext));
    res_sel = (io.in_func == 2'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    unused_prod_hi = ^prod[PW-1:2*XLEN];
  end

  assign stall       = valid_q[LAST] & ~io.out_ready;
  assign io.in_ready = ~stall;

  // Advance the whole pipe unless the output is blocked; flush wins over everything.
  always_comb begin
    valid_d = valid_q;
    stage_d = stage_q;
    if (!stall) begin
      valid_d[0] = io.in_valid;
      if (io.in_valid) begin
        stage_d[0] = '{result: res_sel, rob: io.in_rob_entry, prn: io.in_dest_prn};
      end
      for (int unsigned i = 1; i < STAGES; i++) begin
        valid_d[IW'(i)] = valid_q[IW'(i - 1)];
        stage_d[IW'(i)] = stage_q[IW'(i - 1)];
      end
    end
    if (pipe_flush) begin
      valid_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      stage_q <= '{default: '0};
    end else begin
      valid_q <= valid_d;
      stage_q <= stage_d;
    end
  end

  assign io.out_valid     = valid_q[LAST];
  assign io.out_result    = stage_q[LAST].result;
  assign io.out_rob_entry = stage_q[LAST].rob;
  assign io.out_dest_prn  = stage_q[LAST].prn;

`ifdef MULT_FU_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of blocked cycles; survives flush.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule
